// File: rtl/mem_responder.sv
// Byte-wide RAM responder for the CPU external bus: four-phase rd/wr handshake with programmable wait states.
// Optional MEM_LOADER_EN macro adds a preload write port that yields to CPU traffic.
module mem_responder #(
   parameter int unsigned AW          = 8,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   addr,
   input  logic [7:0]    wdata,
   input  logic          rd,
   input  logic          wr,
`ifdef MEM_LOADER_EN
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [7:0]    ld_wdata,
   output logic          ld_busy,
`endif
   output logic [7:0]    rdata,
   output logic          ack,
   output logic          err,
   output logic          busy
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned WCW   = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE,
      S_HOLD
   } state_t;

   state_t          state_q, state_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic [15:0]     addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            rd_q, rd_d;
   logic            wr_q, wr_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;

   logic [7:0]      mem [DEPTH];
   logic            mem_we_c;
   logic [AW-1:0]   mem_waddr_c;
   logic [7:0]      mem_wdata_c;

   logic            req_c;
   logic            oor_c;
   logic            both_c;
   logic            illegal_c;

   assign req_c     = rd | wr;
   assign oor_c     = (addr_q >> AW) != 16'd0;
   assign both_c    = rd_q & wr_q;
   assign illegal_c = oor_c | both_c;

   // Next-state, datapath and RAM write-port selection
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      rdata_d     = rdata_q;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      busy_d      = busy_q;
      mem_we_c    = 1'b0;
      mem_waddr_c = addr_q[AW-1:0];
      mem_wdata_c = wdata_q;
`ifdef MEM_LOADER_EN
      ld_busy     = (state_q != S_IDLE) | rd | wr;
`endif

      case (state_q)
         S_IDLE: begin
            if (req_c) begin
               addr_d  = addr;
               wdata_d = wdata;
               rd_d    = rd;
               wr_d    = wr;
               busy_d  = 1'b1;
               wcnt_d  = '0;
               state_d = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
            end
         end
         S_WAIT: begin
            if (wcnt_q == WCW'(WAIT_STATES - 1)) begin
               state_d = S_DONE;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         S_DONE: begin
            ack_d  = 1'b1;
            err_d  = illegal_c;
            wcnt_d = '0;
            if (!illegal_c) begin
               if (wr_q) begin
                  mem_we_c = 1'b1;
               end else if (rd_q) begin
                  rdata_d = mem[addr_q[AW-1:0]];
               end
            end else if (oor_c && rd_q && !wr_q) begin
               rdata_d = 8'h00;
            end
            // A request already dropped during WAIT skips HOLD entirely
            if (req_c) begin
               state_d = S_HOLD;
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         S_HOLD: begin
            if (!req_c) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

`ifdef MEM_LOADER_EN
      // Loader only reaches the RAM while the CPU side is completely quiet
      if (ld_we && !ld_busy) begin
         mem_we_c    = 1'b1;
         mem_waddr_c = ld_addr;
         mem_wdata_c = ld_wdata;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= 8'h00;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // RAM is not reset; reset returns the FSM to IDLE so an uncommitted write never lands
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[mem_waddr_c] <= mem_wdata_c;
      end
   end

   assign rdata = rdata_q;
   assign ack   = ack_q;
   assign err   = err_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table on a WAIT_STATES=1 instance plus hand sequences
// for early release, mid-wait reset, zero-wait latency and (with MEM_LOADER_EN) the loader port.
module tb_mem_responder;

   logic        clk;
   logic        rst;
   logic [1:0]  rd_v;
   logic [1:0]  wr_v;
   logic [15:0] addr_v  [2];
   logic [7:0]  wdata_v [2];
   logic [7:0]  rdata_v [2];
   logic [1:0]  ack_v;
   logic [1:0]  err_v;
   logic [1:0]  busy_v;
`ifdef MEM_LOADER_EN
   logic [1:0]  ld_we_v;
   logic [7:0]  ld_addr_v  [2];
   logic [7:0]  ld_wdata_v [2];
   logic [1:0]  ld_busy_v;
`endif

   int nvec;
   int nerr;

   mem_responder #(.AW(8), .WAIT_STATES(1)) dut (
      .clk(clk), .rst(rst), .addr(addr_v[0]), .wdata(wdata_v[0]),
      .rd(rd_v[0]), .wr(wr_v[0]),
`ifdef MEM_LOADER_EN
      .ld_we(ld_we_v[0]), .ld_addr(ld_addr_v[0]), .ld_wdata(ld_wdata_v[0]), .ld_busy(ld_busy_v[0]),
`endif
      .rdata(rdata_v[0]), .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0])
   );

   mem_responder #(.AW(8), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .addr(addr_v[1]), .wdata(wdata_v[1]),
      .rd(rd_v[1]), .wr(wr_v[1]),
`ifdef MEM_LOADER_EN
      .ld_we(ld_we_v[1]), .ld_addr(ld_addr_v[1]), .ld_wdata(ld_wdata_v[1]), .ld_busy(ld_busy_v[1]),
`endif
      .rdata(rdata_v[1]), .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          hold;
      logic [7:0]  exp_rdata;
      logic        exp_err;
   } vec_t;

   localparam int NV = 12;
   vec_t vt [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // One complete four-phase transaction on instance w with full timing checks
   task automatic do_req(input int w, input logic r, input logic wv, input logic [15:0] a,
                         input logic [7:0] d, input int hold, input logic [7:0] exp_rd,
                         input logic exp_err, input int exp_lat, input string nm);
      int lat;
      int extra;
      @(negedge clk);
      rd_v[w] = r; wr_v[w] = wv; addr_v[w] = a; wdata_v[w] = d;
      @(posedge clk);
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (ack_v[w]) begin
            lat = c;
            break;
         end
      end
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, " err"}, 32'(err_v[w]), 32'(exp_err));
      chk({nm, " rdata"}, 32'(rdata_v[w]), 32'(exp_rd));
      chk({nm, " busy_at_ack"}, 32'(busy_v[w]), 32'd1);
      extra = 0;
      for (int c = 0; c < hold; c++) begin
         @(posedge clk); #1;
         if (ack_v[w]) extra++;
      end
      chk({nm, " extra_acks"}, 32'(extra), 32'd0);
      @(negedge clk);
      rd_v[w] = 1'b0; wr_v[w] = 1'b0;
      @(posedge clk); #1;
      chk({nm, " busy_after_release"}, 32'(busy_v[w]), 32'd0);
      chk({nm, " ack_after_release"}, 32'(ack_v[w]), 32'd0);
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      vt[0]  = '{1'b0, 1'b1, 16'h0005, 8'hA5, 0, 8'h00, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 16'h0005, 8'h00, 6, 8'hA5, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 16'h0000, 8'h11, 0, 8'hA5, 1'b0};
      vt[3]  = '{1'b0, 1'b1, 16'h0100, 8'h3C, 0, 8'hA5, 1'b1};
      vt[4]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 0, 8'h11, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 16'h0100, 8'h00, 0, 8'h00, 1'b1};
      vt[6]  = '{1'b1, 1'b1, 16'h0005, 8'hFF, 0, 8'h00, 1'b1};
      vt[7]  = '{1'b1, 1'b0, 16'h0005, 8'h00, 0, 8'hA5, 1'b0};
      vt[8]  = '{1'b0, 1'b1, 16'h00FF, 8'h42, 0, 8'hA5, 1'b0};
      vt[9]  = '{1'b1, 1'b0, 16'h00FF, 8'h00, 2, 8'h42, 1'b0};
      vt[10] = '{1'b1, 1'b0, 16'hFF05, 8'h00, 0, 8'h00, 1'b1};
      vt[11] = '{1'b0, 1'b1, 16'h0010, 8'h99, 0, 8'h00, 1'b0};

      rst = 1'b0;
      rd_v = '0; wr_v = '0;
      for (int i = 0; i < 2; i++) begin
         addr_v[i] = '0; wdata_v[i] = '0;
      end
`ifdef MEM_LOADER_EN
      ld_we_v = '0;
      for (int i = 0; i < 2; i++) begin
         ld_addr_v[i] = '0; ld_wdata_v[i] = '0;
      end
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset rdata", 32'(rdata_v[0]), 32'h00);
      chk("reset ack", 32'(ack_v[0]), 32'd0);
      chk("reset err", 32'(err_v[0]), 32'd0);
      chk("reset busy", 32'(busy_v[0]), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle ack", 32'(ack_v[0]), 32'd0);
      chk("idle busy", 32'(busy_v[0]), 32'd0);

      // Vector table on the WAIT_STATES=1 instance
      for (int i = 0; i < NV; i++) begin
         do_req(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].hold,
                vt[i].exp_rdata, vt[i].exp_err, 2, $sformatf("vec%0d", i));
      end

      // Request dropped during WAIT: access still completes, then straight to IDLE
      @(negedge clk);
      rd_v[0] = 1'b1; addr_v[0] = 16'h0005;
      @(posedge clk);
      @(negedge clk);
      rd_v[0] = 1'b0;
      @(posedge clk); #1;
      chk("early_drop ack_before", 32'(ack_v[0]), 32'd0);
      @(posedge clk); #1;
      chk("early_drop ack", 32'(ack_v[0]), 32'd1);
      chk("early_drop rdata", 32'(rdata_v[0]), 32'hA5);
      chk("early_drop busy", 32'(busy_v[0]), 32'd0);
      @(posedge clk); #1;
      chk("early_drop ack_after", 32'(ack_v[0]), 32'd0);

      // Reset during WAIT abandons the write to 0x10
      @(negedge clk);
      wr_v[0] = 1'b1; addr_v[0] = 16'h0010; wdata_v[0] = 8'h77;
      @(posedge clk); #1;
      chk("rst_mid busy_accepted", 32'(busy_v[0]), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid busy", 32'(busy_v[0]), 32'd0);
      chk("rst_mid rdata", 32'(rdata_v[0]), 32'h00);
      wr_v[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      do_req(0, 1'b1, 1'b0, 16'h0010, 8'h00, 0, 8'h99, 1'b0, 2, "rst_mid readback");

      // Zero wait states: ack one cycle after acceptance
      do_req(1, 1'b0, 1'b1, 16'h0007, 8'h5C, 0, 8'h00, 1'b0, 1, "ws0 write");
      do_req(1, 1'b1, 1'b0, 16'h0007, 8'h00, 3, 8'h5C, 1'b0, 1, "ws0 read");
      do_req(1, 1'b1, 1'b0, 16'h0300, 8'h00, 0, 8'h00, 1'b1, 1, "ws0 oor");

`ifdef MEM_LOADER_EN
      // Loader preload while idle, then read back through the CPU bus
      @(negedge clk);
      #1;
      chk("ld idle ld_busy", 32'(ld_busy_v[0]), 32'd0);
      ld_we_v[0] = 1'b1; ld_addr_v[0] = 8'h20; ld_wdata_v[0] = 8'h5A;
      @(negedge clk);
      ld_we_v[0] = 1'b0;
      rd_v[0] = 1'b1; addr_v[0] = 16'h0005;
      #1;
      chk("ld req ld_busy", 32'(ld_busy_v[0]), 32'd1);
      ld_we_v[0] = 1'b1; ld_addr_v[0] = 8'h20; ld_wdata_v[0] = 8'hEE;
      @(negedge clk);
      ld_we_v[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rd_v[0] = 1'b0;
      repeat (2) @(posedge clk);
      do_req(0, 1'b1, 1'b0, 16'h0020, 8'h00, 0, 8'h5A, 1'b0, 2, "ld readback");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
